// File: rtl/para_setting_if.sv
// Parameter-setting receiver bus: MCU frame-start/control code, UART RX byte
// stream, UART TX reply handshake and the committed parameter/strobe outputs.
// Ports: para_setting_flag/ctrl_code, rx_data/rx_ok, tx_idle/tx_data/start_tx,
//        para_out/para_cs, set_para_done, para_err, module_run_flag.
interface para_setting_if #(
  parameter int NUM_PARA = 6
);
  logic                     para_setting_flag;
  logic [7:0]               ctrl_code;
  logic [7:0]               rx_data;
  logic                     rx_ok;
  logic                     tx_idle;
  logic [7:0]               tx_data;
  logic                     start_tx;
  logic [NUM_PARA*32-1:0]   para_out;
  logic [NUM_PARA-1:0]      para_cs;
  logic                     set_para_done;
  logic                     para_err;
  logic                     module_run_flag;

  // Environment side: MCU front end, UART RX/TX and config-register consumer.
  modport master (
    output para_setting_flag, ctrl_code, rx_data, rx_ok, tx_idle,
    input  tx_data, start_tx, para_out, para_cs, set_para_done, para_err,
           module_run_flag
  );

  // Receiver side.
  modport slave (
    input  para_setting_flag, ctrl_code, rx_data, rx_ok, tx_idle,
    output tx_data, start_tx, para_out, para_cs, set_para_done, para_err,
           module_run_flag
  );
endinterface

// File: rtl/para_setting_gen.sv
// Parameter-setting receiver: captures NUM_PARA 32-bit slots from a UART frame,
// verifies length/checksum/end code, commits atomically and strobes changed slots,
// then replies OK/ERR over UART TX.
// Ports: clk, rst_n (async active-low), bus (para_setting_if.slave) carrying the
//        frame-start/control code, UART RX/TX handshake and committed outputs.
module para_setting_gen #(
  parameter int         NUM_PARA     = 6,
  parameter logic [7:0] START_CODE   = 8'hAA,
  parameter logic [7:0] END_CODE     = 8'h55,
  parameter int         CS_HOLD      = 20,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter bit         FORCE_ALL_CS = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  para_setting_if.slave bus
);

  localparam int PAY_BYTES = NUM_PARA * 4;
  localparam int PW        = NUM_PARA * 32;
  localparam int IDX_W     = $clog2(PW);

  localparam logic [6:0]  PAY_LAST = 7'(PAY_BYTES - 1);
  localparam logic [15:0] LEN_EXP  = 16'(PAY_BYTES);
  localparam logic [7:0]  CS_LAST  = 8'(CS_HOLD - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_LEN,
    S_RX_PAY,
    S_RX_CRC,
    S_RX_END,
    S_CHECK,
    S_COMMIT,
    S_CS,
    S_REPLY
  } state_t;

  // Per-byte reply handshake: present tx_data, fire start_tx once the UART is
  // idle, then wait for the UART to report completion.
  typedef enum logic [1:0] {
    TX_LOAD,
    TX_FIRE,
    TX_WAIT
  } tx_ph_t;

  state_t            state, state_nxt;
  tx_ph_t            tx_ph;

  logic [2:0]        rx_sync;
  logic [2:0]        idle_sync;
  logic              byte_ev;
  logic              tx_idle_s;
  logic              tx_rise;

  logic [7:0]        ctrl_lat;
  logic [7:0]        sum;
  logic [6:0]        byte_cnt;
  logic [7:0]        len_lo, len_hi;
  logic [7:0]        crc_b, end_b;
  logic [PW-1:0]     shadow;
  logic [PW-1:0]     para_out_r;
  logic [NUM_PARA-1:0] changed_c, changed_r;
  logic [7:0]        cs_cnt;
  logic [31:0]       tmo_cnt;
  logic [7:0]        status;
  logic [2:0]        tx_cnt;
  logic [7:0]        tx_data_r;
  logic              start_tx_r;
  logic              run_flag;

  logic              in_rx;
  logic              tmo_hit;
  logic              frame_ok;
  logic              tx_done;
  logic              last_done;
  logic [7:0]        reply_byte;
  logic [7:0]        reply_ck;
  logic [IDX_W-1:0]  pay_bit;

  logic              para_err_c;
  logic              set_done_c;
  logic [NUM_PARA-1:0] cs_c;

  // ---------------------------------------------------------------------------
  // Synchronisers. Index [1] is the synchronised level, [2] its one-cycle delay
  // used for rising-edge detection.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync   <= '0;
      idle_sync <= '0;
    end else begin
      rx_sync   <= {rx_sync[1:0], bus.rx_ok};
      idle_sync <= {idle_sync[1:0], bus.tx_idle};
    end
  end

  assign byte_ev   = rx_sync[1] & ~rx_sync[2];
  assign tx_idle_s = idle_sync[1];
  assign tx_rise   = idle_sync[1] & ~idle_sync[2];

  assign in_rx   = (state == S_RX_LEN) || (state == S_RX_PAY) ||
                   (state == S_RX_CRC) || (state == S_RX_END);
  // A byte arriving in the last allowed cycle still counts.
  assign tmo_hit = in_rx && !byte_ev && (tmo_cnt == TMO_LAST);

  assign frame_ok = ({len_hi, len_lo} == LEN_EXP) &&
                    (crc_b == ~sum) &&
                    (end_b == END_CODE);

  // Only an idle rising edge seen while waiting on our own start_tx counts.
  assign tx_done   = (state == S_REPLY) && (tx_ph == TX_WAIT) && tx_rise;
  assign last_done = tx_done && (tx_cnt == 3'd6);

  // Little-endian payload: byte k lands at bit 8k, i.e. slot k/4, lane k%4.
  assign pay_bit = IDX_W'({byte_cnt, 3'b000});

  always_comb begin
    changed_c = '0;
    for (int i = 0; i < NUM_PARA; i++) begin
      changed_c[i] = FORCE_ALL_CS || (shadow[32*i +: 32] != para_out_r[32*i +: 32]);
    end
  end

  assign reply_ck = ~(ctrl_lat + 8'h01 + 8'h00 + status);

  always_comb begin
    reply_byte = START_CODE;
    case (tx_cnt)
      3'd0:    reply_byte = START_CODE;
      3'd1:    reply_byte = ctrl_lat;
      3'd2:    reply_byte = 8'h01;
      3'd3:    reply_byte = 8'h00;
      3'd4:    reply_byte = status;
      3'd5:    reply_byte = reply_ck;
      default: reply_byte = END_CODE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    para_err_c = 1'b0;
    set_done_c = 1'b0;
    cs_c       = '0;
    case (state)
      S_IDLE: begin
        if (bus.para_setting_flag) state_nxt = S_RX_LEN;
      end
      S_RX_LEN: begin
        if (tmo_hit) begin
          state_nxt  = S_REPLY;
          para_err_c = 1'b1;
        end else if (byte_ev && byte_cnt == 7'd1) begin
          state_nxt = S_RX_PAY;
        end
      end
      S_RX_PAY: begin
        if (tmo_hit) begin
          state_nxt  = S_REPLY;
          para_err_c = 1'b1;
        end else if (byte_ev && byte_cnt == PAY_LAST) begin
          state_nxt = S_RX_CRC;
        end
      end
      S_RX_CRC: begin
        if (tmo_hit) begin
          state_nxt  = S_REPLY;
          para_err_c = 1'b1;
        end else if (byte_ev) begin
          state_nxt = S_RX_END;
        end
      end
      S_RX_END: begin
        if (tmo_hit) begin
          state_nxt  = S_REPLY;
          para_err_c = 1'b1;
        end else if (byte_ev) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_ok) begin
          state_nxt = S_COMMIT;
        end else begin
          state_nxt  = S_REPLY;
          para_err_c = 1'b1;
        end
      end
      S_COMMIT: state_nxt = S_CS;
      S_CS: begin
        cs_c = changed_r;
        if (cs_cnt == CS_LAST) state_nxt = S_REPLY;
      end
      S_REPLY: begin
        if (last_done) begin
          state_nxt  = S_IDLE;
          set_done_c = (status == 8'hFF);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_lat   <= '0;
      sum        <= '0;
      byte_cnt   <= '0;
      len_lo     <= '0;
      len_hi     <= '0;
      crc_b      <= '0;
      end_b      <= '0;
      shadow     <= '0;
      para_out_r <= '0;
      changed_r  <= '0;
      cs_cnt     <= '0;
      tmo_cnt    <= '0;
      status     <= '0;
      tx_cnt     <= '0;
      tx_ph      <= TX_LOAD;
      tx_data_r  <= '0;
      start_tx_r <= 1'b0;
      run_flag   <= 1'b0;
    end else begin
      start_tx_r <= 1'b0;

      if (in_rx) begin
        if (byte_ev) tmo_cnt <= '0;
        else         tmo_cnt <= tmo_cnt + 32'd1;
      end

      case (state)
        S_IDLE: begin
          if (bus.para_setting_flag) begin
            ctrl_lat <= bus.ctrl_code;
            sum      <= bus.ctrl_code;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            shadow   <= '0;
            status   <= 8'h00;
          end
        end
        S_RX_LEN: begin
          if (byte_ev) begin
            sum <= sum + bus.rx_data;
            if (byte_cnt == 7'd0) begin
              len_lo   <= bus.rx_data;
              byte_cnt <= 7'd1;
            end else begin
              len_hi   <= bus.rx_data;
              byte_cnt <= 7'd0;
            end
          end
        end
        S_RX_PAY: begin
          if (byte_ev) begin
            shadow[pay_bit +: 8] <= bus.rx_data;
            sum                  <= sum + bus.rx_data;
            byte_cnt             <= byte_cnt + 7'd1;
          end
        end
        S_RX_CRC: begin
          if (byte_ev) crc_b <= bus.rx_data;
        end
        S_RX_END: begin
          if (byte_ev) end_b <= bus.rx_data;
        end
        S_CHECK: begin
          status <= frame_ok ? 8'hFF : 8'h00;
        end
        S_COMMIT: begin
          para_out_r <= shadow;
          changed_r  <= changed_c;
          cs_cnt     <= '0;
        end
        S_CS: begin
          cs_cnt <= cs_cnt + 8'd1;
        end
        S_REPLY: begin
          case (tx_ph)
            TX_LOAD: begin
              tx_data_r <= reply_byte;
              tx_ph     <= TX_FIRE;
            end
            TX_FIRE: begin
              if (tx_idle_s) begin
                start_tx_r <= 1'b1;
                tx_ph      <= TX_WAIT;
              end
            end
            default: begin
              if (tx_done) begin
                tx_cnt <= tx_cnt + 3'd1;
                tx_ph  <= TX_LOAD;
              end
            end
          endcase
        end
        default: ;
      endcase

      // A timed-out frame never reaches commit; drop its partial payload.
      if (tmo_hit) shadow <= '0;

      if (state != S_REPLY && state_nxt == S_REPLY) begin
        run_flag <= 1'b1;
        tx_cnt   <= '0;
        tx_ph    <= TX_LOAD;
      end else if (last_done) begin
        run_flag <= 1'b0;
      end
    end
  end

  assign bus.tx_data         = tx_data_r;
  assign bus.start_tx        = start_tx_r;
  assign bus.para_out        = para_out_r;
  assign bus.para_cs         = cs_c;
  assign bus.set_para_done   = set_done_c;
  assign bus.para_err        = para_err_c;
  assign bus.module_run_flag = run_flag;

endmodule

// File: tb/tb_para_setting_gen.sv
module tb_para_setting_gen;
  localparam int NP  = 6;
  localparam int PB  = NP * 4;
  localparam int CSH = 20;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  para_setting_if #(.NUM_PARA(NP)) bus();

  para_setting_gen #(
    .NUM_PARA(NP), .START_CODE(8'hAA), .END_CODE(8'h55),
    .CS_HOLD(CSH), .TIMEOUT_CYC(TMO), .FORCE_ALL_CS(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic              ok;
    logic [NP*32-1:0]  para;
    logic [NP-1:0]     cs;
  } res_t;

  res_t        exp_res[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] model [NP];
  logic [31:0] fv [NP];

  int n_checks = 0;
  int n_errors = 0;
  int tx_seen  = 0;
  int cs_cycles = 0;
  logic [NP-1:0] cs_val = '0;
  logic cs_incons = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP*32-1:0] model_vec();
    logic [NP*32-1:0] v;
    for (int i = 0; i < NP; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // UART TX model: goes busy for a few cycles after each start_tx.
  initial begin
    bus.tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && bus.start_tx) begin
        bus.tx_idle = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        bus.tx_idle = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a reply byte or verdict.
  initial begin : monitor
    res_t r;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_cycles = 0;
        cs_val    = '0;
        cs_incons = 1'b0;
      end else begin
        if (bus.para_cs != '0) begin
          if (cs_cycles != 0 && bus.para_cs != cs_val) cs_incons = 1'b1;
          cs_val = bus.para_cs;
          cs_cycles++;
        end
        if (bus.start_tx) begin
          tx_seen++;
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_unexpected: got byte %0h expected no byte", bus.tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", bus.tx_data, e);
          end
        end
        if (bus.para_err || bus.set_para_done) begin
          if (exp_res.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL verdict_unexpected: got done=%0b err=%0b expected none",
                     bus.set_para_done, bus.para_err);
          end else begin
            r = exp_res.pop_front();
            chk("verdict", {bus.set_para_done, bus.para_err}, r.ok ? 2'b10 : 2'b01);
            chk("para_out", bus.para_out, r.para);
            chk("cs_cycles", cs_cycles, (r.ok && r.cs != '0) ? CSH : 0);
            chk("cs_value", (cs_cycles != 0) ? cs_val : '0, r.ok ? r.cs : '0);
            chk("cs_stable", cs_incons, 1'b0);
          end
          cs_cycles = 0;
          cs_val    = '0;
          cs_incons = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_ok   = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_ok = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic start_frame(input logic [7:0] cc);
    @(negedge clk);
    bus.ctrl_code         = cc;
    bus.para_setting_flag = 1'b1;
    @(negedge clk);
    bus.para_setting_flag = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_reply(input logic [7:0] cc, input logic [7:0] st);
    logic [7:0] ck;
    ck = ~(cc + 8'h01 + 8'h00 + st);
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(cc);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(st);
    exp_tx.push_back(ck);
    exp_tx.push_back(8'h55);
  endtask

  task automatic wait_done();
    bit saw, done;
    saw  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (bus.module_run_flag) saw = 1'b1;
      else if (saw)            done = 1'b1;
    end
    chk("reply_complete", done, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // kind: 0 good, 1 crc off by one, 2 length 23, 3 end byte 00.
  task automatic run_frame(input logic [7:0] cc, input int kind, input bit do_wait);
    logic [7:0]  q[$];
    logic [7:0]  sum, crc, endb;
    logic [15:0] lenv;
    logic        ok;
    res_t        r;
    lenv = (kind == 2) ? 16'(PB - 1) : 16'(PB);
    q.push_back(lenv[7:0]);
    q.push_back(lenv[15:8]);
    for (int s = 0; s < NP; s++)
      for (int l = 0; l < 4; l++) q.push_back(fv[s][8*l +: 8]);
    sum = cc;
    foreach (q[k]) sum = sum + q[k];
    crc = ~sum;
    if (kind == 1) crc = crc + 8'd1;
    endb = (kind == 3) ? 8'h00 : 8'h55;
    ok = (lenv == 16'(PB)) && (crc == ~sum) && (endb == 8'h55);
    r.ok = ok;
    r.cs = '0;
    if (ok) begin
      for (int s = 0; s < NP; s++) begin
        r.cs[s]  = (fv[s] != model[s]);
        model[s] = fv[s];
      end
    end
    r.para = model_vec();
    exp_res.push_back(r);
    push_reply(cc, ok ? 8'hFF : 8'h00);
    start_frame(cc);
    foreach (q[k]) send_byte(q[k]);
    send_byte(crc);
    send_byte(endb);
    if (do_wait) wait_done();
  endtask

  task automatic timeout_frame(input logic [7:0] cc);
    res_t r;
    r.ok   = 1'b0;
    r.cs   = '0;
    r.para = model_vec();
    exp_res.push_back(r);
    push_reply(cc, 8'h00);
    start_frame(cc);
    send_byte(8'(PB));
    send_byte(8'h00);
    for (int k = 0; k < 10; k++) send_byte(8'($urandom));
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, kind;
    bit reached;
    bus.para_setting_flag = 1'b0;
    bus.ctrl_code = 8'h00;
    bus.rx_data   = 8'h00;
    bus.rx_ok     = 1'b0;
    for (int i = 0; i < NP; i++) begin
      model[i] = '0;
      fv[i]    = '0;
    end

    repeat (4) @(negedge clk);
    chk("rst_para_out", bus.para_out, '0);
    chk("rst_para_cs", bus.para_cs, '0);
    chk("rst_start_tx", bus.start_tx, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_done", bus.set_para_done, 1'b0);
    chk("rst_err", bus.para_err, 1'b0);
    chk("rst_run", bus.module_run_flag, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed frames.
    fv[0] = 32'h0001_86A0;
    run_frame(8'h3C, 0, 1'b1);
    chk("slot0_value", bus.para_out[31:0], 32'h0001_86A0);
    run_frame(8'h3C, 0, 1'b1);
    fv[1] = 32'hDEAD_BEEF;
    run_frame(8'h11, 1, 1'b1);
    run_frame(8'h22, 2, 1'b1);
    run_frame(8'h33, 3, 1'b1);
    timeout_frame(8'h44);
    fv[2] = 32'h1234_5678;
    run_frame(8'h55, 0, 1'b1);

    // Randomised frames.
    for (int n = 0; n < 10; n++) begin
      for (int s = 0; s < NP; s++)
        if ($urandom_range(0, 1) == 1) fv[s] = $urandom;
      kind = $urandom_range(0, 5);
      kind = (kind <= 2) ? 0 : kind - 2;
      run_frame(8'($urandom), kind, 1'b1);
    end

    // Reset during the third reply byte.
    for (int s = 0; s < NP; s++) fv[s] = $urandom;
    base = tx_seen;
    run_frame(8'h7E, 0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      @(negedge clk);
      if (tx_seen >= base + 3) reached = 1'b1;
    end
    chk("reach_byte3", reached, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_start_tx", bus.start_tx, 1'b0);
    chk("arst_run", bus.module_run_flag, 1'b0);
    chk("arst_para_out", bus.para_out, '0);
    chk("arst_para_cs", bus.para_cs, '0);
    exp_tx.delete();
    exp_res.delete();
    for (int s = 0; s < NP; s++) model[s] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = tx_seen;
    repeat (300) @(negedge clk);
    chk("no_tx_after_reset", tx_seen, base);
    chk("idle_after_reset", bus.module_run_flag, 1'b0);

    // Recovery.
    run_frame(8'h5A, 0, 1'b1);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
